// File: rtl/pbtn_events_if.sv
// Pushbutton event bus: debounced levels and controls in, event pulses and
// sticky pending flags out. The master drives the inputs; pbtn_events is the slave.
interface pbtn_events_if #(
    parameter int N_PB = 5
);
    logic [N_PB-1:0] pbtn_db;
    logic [N_PB-1:0] repeat_en;
    logic [N_PB-1:0] ev_clr;
    logic [N_PB-1:0] press_pulse;
    logic [N_PB-1:0] repeat_pulse;
    logic [N_PB-1:0] release_pulse;
    logic [N_PB-1:0] ev_pulse;
    logic [N_PB-1:0] ev_pending;

    modport master (
        output pbtn_db, repeat_en, ev_clr,
        input  press_pulse, repeat_pulse, release_pulse, ev_pulse, ev_pending
    );

    modport slave (
        input  pbtn_db, repeat_en, ev_clr,
        output press_pulse, repeat_pulse, release_pulse, ev_pulse, ev_pending
    );
endinterface

// File: rtl/pbtn_events.sv
// Turns debounced pushbutton levels into one-cycle press / auto-repeat /
// release events and sticky pending flags. Every button has an independent
// FSM and hold/repeat counter; all outputs are registered.
module pbtn_events #(
    parameter int N_PB          = 5,
    parameter int SIMULATE      = 0,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic         SI_ClkIn,
    input  logic         SI_Reset_N,
    pbtn_events_if.slave bus
);

    localparam int HOLD_EFF   = (SIMULATE != 0) ? 20 : HOLD_CYCLES;
    localparam int REPEAT_EFF = (SIMULATE != 0) ? 5  : REPEAT_CYCLES;
    localparam int MAX_EFF    = (HOLD_EFF > REPEAT_EFF) ? HOLD_EFF : REPEAT_EFF;
    localparam int CNT_W      = $clog2(MAX_EFF) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_EFF - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT,
        ST_HELD,
        ST_BLOCKED
    } state_t;

    state_t           state [N_PB];
    logic [CNT_W-1:0] cnt   [N_PB];
    logic             prime;
    logic [N_PB-1:0]  prev;
    logic [N_PB-1:0]  press_ev;
    logic [N_PB-1:0]  repeat_ev;
    logic [N_PB-1:0]  release_ev;

    // Decide which events each button raises at the coming edge; release
    // wins over a repeat because a repeat needs the button still held.
    always_comb begin
        press_ev   = '0;
        repeat_ev  = '0;
        release_ev = '0;
        for (int i = 0; i < N_PB; i++) begin
            press_ev[i]   = prime && (state[i] == ST_IDLE) &&
                            bus.pbtn_db[i] && !prev[i];
            release_ev[i] = prime && !bus.pbtn_db[i] &&
                            ((state[i] == ST_DELAY) || (state[i] == ST_REPEAT) ||
                             (state[i] == ST_HELD));
            repeat_ev[i]  = prime && bus.pbtn_db[i] && bus.repeat_en[i] &&
                            (((state[i] == ST_DELAY)  && (cnt[i] == HOLD_LAST)) ||
                             ((state[i] == ST_REPEAT) && (cnt[i] == REPEAT_LAST)));
        end
    end

    // Per-button FSMs, counters and registered outputs. A pending flag being
    // cleared while its ev_pulse is on the bus stays set, so a clear can never
    // swallow an event the reader has not seen yet.
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            prime             <= 1'b0;
            prev              <= '0;
            bus.press_pulse   <= '0;
            bus.repeat_pulse  <= '0;
            bus.release_pulse <= '0;
            bus.ev_pulse      <= '0;
            bus.ev_pending    <= '0;
            for (int i = 0; i < N_PB; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            prime             <= 1'b1;
            prev              <= bus.pbtn_db;
            bus.press_pulse   <= press_ev;
            bus.repeat_pulse  <= repeat_ev;
            bus.release_pulse <= release_ev;
            bus.ev_pulse      <= press_ev | repeat_ev;
            bus.ev_pending    <= press_ev | repeat_ev | bus.ev_pulse |
                                 (bus.ev_pending & ~bus.ev_clr);
            for (int i = 0; i < N_PB; i++) begin
                if (!prime) begin
                    state[i] <= bus.pbtn_db[i] ? ST_BLOCKED : ST_IDLE;
                    cnt[i]   <= '0;
                end else begin
                    case (state[i])
                        ST_IDLE: begin
                            if (press_ev[i]) begin
                                state[i] <= bus.repeat_en[i] ? ST_DELAY : ST_HELD;
                                cnt[i]   <= '0;
                            end
                        end
                        ST_DELAY, ST_REPEAT: begin
                            if (!bus.pbtn_db[i]) begin
                                state[i] <= ST_IDLE;
                                cnt[i]   <= '0;
                            end else if (!bus.repeat_en[i]) begin
                                state[i] <= ST_HELD;
                                cnt[i]   <= '0;
                            end else if (repeat_ev[i]) begin
                                state[i] <= ST_REPEAT;
                                cnt[i]   <= '0;
                            end else begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                        ST_HELD, ST_BLOCKED: begin
                            if (!bus.pbtn_db[i]) begin
                                state[i] <= ST_IDLE;
                                cnt[i]   <= '0;
                            end
                        end
                        default: begin
                            state[i] <= ST_IDLE;
                            cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pbtn_events.sv
// Testbench for pbtn_events with the short simulation timing
// (hold 20 cycles, repeat every 5 cycles).
module tb_pbtn_events;

    localparam int N = 5;

    logic SI_ClkIn   = 1'b0;
    logic SI_Reset_N = 1'b0;

    pbtn_events_if #(.N_PB(N)) bus ();

    pbtn_events #(
        .N_PB     (N),
        .SIMULATE (1)
    ) dut (
        .SI_ClkIn   (SI_ClkIn),
        .SI_Reset_N (SI_Reset_N),
        .bus        (bus)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    always #5 SI_ClkIn = ~SI_ClkIn;

    typedef struct {
        logic [4:0] btn;
        logic [4:0] ren;
        logic [4:0] clr;
        logic [4:0] press;
        logic [4:0] rep;
        logic [4:0] rel;
        logic [4:0] ev;
        logic [4:0] pend;
    } vec_t;

    vec_t tbl [18];
    int   checks = 0;
    int   errors = 0;
    int   evCount;

    // Drive one cycle of inputs, clock it in, and settle 1 ns after the edge.
    task automatic applyStimulus(input logic [4:0] btn, input logic [4:0] ren,
                                 input logic [4:0] clr);
        bus.pbtn_db   = btn;
        bus.repeat_en = ren;
        bus.ev_clr    = clr;
        @(posedge SI_ClkIn);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pulsesNow();
        return {17'b0, bus.press_pulse, bus.repeat_pulse, bus.release_pulse};
    endfunction

    function automatic logic [31:0] allNow();
        return {7'b0, bus.press_pulse, bus.repeat_pulse, bus.release_pulse,
                bus.ev_pulse, bus.ev_pending};
    endfunction

    function automatic logic [31:0] allExp(input vec_t v);
        return {7'b0, v.press, v.rep, v.rel, v.ev, v.pend};
    endfunction

    // Expected pulses of a held button with repeat enabled, j edges after the rise.
    function automatic logic [31:0] holdExp(input int j, input logic [4:0] mask,
                                            input int lastRepeat);
        logic [4:0] p;
        logic [4:0] r;
        p = (j == 1) ? mask : 5'b0;
        r = (j >= 21 && j <= lastRepeat && ((j - 21) % 5 == 0)) ? mask : 5'b0;
        return {17'b0, p, r, 5'b0};
    endfunction

    initial begin
        //           btn       ren       clr       press     rep    rel       ev        pend
        tbl[0]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000};
        tbl[1]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 5'b0, 5'b00000, 5'b00001, 5'b00001};
        tbl[2]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00001};
        tbl[3]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00001};
        tbl[4]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00001, 5'b00000, 5'b00001};
        tbl[5]  = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00001};
        tbl[6]  = '{5'b00000, 5'b00000, 5'b00001, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000};
        tbl[7]  = '{5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b0, 5'b00000, 5'b01000, 5'b01000};
        tbl[8]  = '{5'b01000, 5'b00000, 5'b01000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b01000};
        tbl[9]  = '{5'b01000, 5'b00000, 5'b01000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000};
        tbl[10] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b01000, 5'b00000, 5'b00000};
        tbl[11] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000};
        tbl[12] = '{5'b00011, 5'b00000, 5'b00000, 5'b00011, 5'b0, 5'b00000, 5'b00011, 5'b00011};
        tbl[13] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b0, 5'b00011, 5'b00000, 5'b00011};
        tbl[14] = '{5'b00000, 5'b00000, 5'b00011, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000};
        tbl[15] = '{5'b10000, 5'b10000, 5'b00000, 5'b10000, 5'b0, 5'b00000, 5'b10000, 5'b10000};
        tbl[16] = '{5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b0, 5'b10000, 5'b00000, 5'b10000};
        tbl[17] = '{5'b00000, 5'b00000, 5'b10000, 5'b00000, 5'b0, 5'b00000, 5'b00000, 5'b00000};

        bus.pbtn_db   = '0;
        bus.repeat_en = '0;
        bus.ev_clr    = '0;
        #22;
        checkOutput("reset_state", allNow(), 32'h0);
        SI_Reset_N = 1'b1;

        // Table: priming edge, tap, pending clears and collision, simultaneous buttons.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i].btn, tbl[i].ren, tbl[i].clr);
            checkOutput($sformatf("vec%0d", i), allNow(), allExp(tbl[i]));
        end

        // Hold btn2 for 50 cycles with repeat enabled.
        $display("[TB] hold with repeat on btn2");
        evCount = 0;
        for (int j = 1; j <= 50; j++) begin
            applyStimulus(5'b00100, 5'b00100, 5'b00000);
            checkOutput($sformatf("hold_j%0d", j), pulsesNow(), holdExp(j, 5'b00100, 50));
            if (bus.ev_pulse[2]) evCount++;
        end
        applyStimulus(5'b00000, 5'b00100, 5'b00000);
        checkOutput("hold_release", pulsesNow(), {17'b0, 5'b0, 5'b0, 5'b00100});
        checkOutput("hold_ev_count", 32'(evCount), 32'd7);
        checkOutput("hold_pending", {27'b0, bus.ev_pending}, {27'b0, 5'b00100});
        applyStimulus(5'b00000, 5'b00000, 5'b00100);

        // Repeat enable dropped two cycles after the first repeat.
        $display("[TB] repeat disabled mid-hold on btn2");
        for (int j = 1; j <= 30; j++) begin
            applyStimulus(5'b00100, (j <= 22) ? 5'b00100 : 5'b00000, 5'b00000);
            checkOutput($sformatf("dis_j%0d", j), pulsesNow(), holdExp(j, 5'b00100, 21));
        end
        applyStimulus(5'b00000, 5'b00000, 5'b00000);
        checkOutput("dis_release", pulsesNow(), {17'b0, 5'b0, 5'b0, 5'b00100});
        applyStimulus(5'b00000, 5'b00000, 5'b00100);

        // Buttons 0..2 held across reset release.
        $display("[TB] buttons held through reset");
        bus.pbtn_db = 5'b00111;
        SI_Reset_N  = 1'b0;
        @(posedge SI_ClkIn);
        #3;
        checkOutput("blk_in_reset", allNow(), 32'h0);
        SI_Reset_N = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(5'b00111, 5'b00000, 5'b00000);
            checkOutput($sformatf("blk_hold%0d", j), allNow(), 32'h0);
        end
        for (int j = 1; j <= 3; j++) begin
            applyStimulus(5'b00101, 5'b00000, 5'b00000);
            checkOutput($sformatf("blk_rel%0d", j), allNow(), 32'h0);
        end
        applyStimulus(5'b00111, 5'b00000, 5'b00000);
        checkOutput("blk_repress", allNow(),
                    {7'b0, 5'b00010, 5'b0, 5'b0, 5'b00010, 5'b00010});
        applyStimulus(5'b00000, 5'b00000, 5'b00000);
        checkOutput("blk_release_all", pulsesNow(), {17'b0, 5'b0, 5'b0, 5'b00010});
        applyStimulus(5'b00000, 5'b00000, 5'b00010);

        // Asynchronous reset right after a repeat pulse on btn4.
        $display("[TB] async reset mid-repeat on btn4");
        for (int j = 1; j <= 21; j++) begin
            applyStimulus(5'b10000, 5'b10000, 5'b00000);
            checkOutput($sformatf("ar_j%0d", j), pulsesNow(), holdExp(j, 5'b10000, 21));
        end
        #2;
        SI_Reset_N = 1'b0;
        #1;
        checkOutput("ar_cleared", allNow(), 32'h0);
        #2;
        SI_Reset_N = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            applyStimulus(5'b10000, 5'b10000, 5'b00000);
            checkOutput($sformatf("ar_quiet%0d", j), allNow(), 32'h0);
        end
        for (int j = 1; j <= 2; j++) begin
            applyStimulus(5'b00000, 5'b10000, 5'b00000);
            checkOutput($sformatf("ar_rel%0d", j), allNow(), 32'h0);
        end
        applyStimulus(5'b10000, 5'b10000, 5'b00000);
        checkOutput("ar_repress", allNow(),
                    {7'b0, 5'b10000, 5'b0, 5'b0, 5'b10000, 5'b10000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
